mem_io_bridge: RTL

//  Memory/IO stage directly downstream of the controller and ALU. Decodes the ALU address

---
 rtl/mem_io_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_io_bridge.sv
// Memory/IO stage between the ALU and the register-file write-back decoder.
// Decodes the effective address into data-memory or IO space, owns the 24-bit LED register
// and the synchronized switch image, and muxes load data back to the decoder.
// Optional feature: define IO_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable samples before a
// switch change is accepted; otherwise the synchronized switches are taken every cycle.
module mem_io_bridge #(
`ifdef IO_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DEBOUNCE_W      = 20,
`endif
  parameter logic [21:0] IO_BASE_HI      = 22'h3FFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr_in,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IORead,
  input  logic        IOWrite,
  input  logic [31:0] m_rdata,
  input  logic [31:0] r_rdata,
  input  logic [23:0] switch,
  output logic [31:0] r_wdata,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        mem_wen,
  output logic [23:0] LED,
  output logic        sw_event
);

  localparam logic [7:0] OffLedLo = 8'h60;
  localparam logic [7:0] OffLedHi = 8'h62;
  localparam logic [7:0] OffSwLo  = 8'h70;
  localparam logic [7:0] OffSwHi  = 8'h72;

  logic        io_hit;
  logic [7:0]  io_off;
  logic [31:0] io_rdata;

  logic [23:0] led_q, led_d;
  logic [23:0] sw_s1_q, sw_s1_d;
  logic [23:0] sw_s2_q, sw_s2_d;
  logic [23:0] sw_stable_q, sw_stable_d;
  logic        sw_event_q, sw_event_d;

`ifdef IO_DEBOUNCE_EN
  localparam logic [DEBOUNCE_W-1:0] CntLast = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
`endif

  assign io_hit     = (addr_in[31:10] == IO_BASE_HI);
  assign io_off     = addr_in[7:0];
  assign address    = addr_in;
  assign write_data = r_rdata;
  assign mem_wen    = MemWrite;
  assign LED        = led_q;
  assign sw_event   = sw_event_q;

  // IO read field select and load mux; IO wins over memory when both are requested.
  always_comb begin
    io_rdata = '0;
    if (io_hit) begin
      case (io_off)
        OffLedLo: io_rdata = {16'h0, led_q[15:0]};
        OffLedHi: io_rdata = {24'h0, led_q[23:16]};
        OffSwLo:  io_rdata = {16'h0, sw_stable_q[15:0]};
        OffSwHi:  io_rdata = {24'h0, sw_stable_q[23:16]};
        default:  io_rdata = '0;
      endcase
    end
    r_wdata = '0;
    if (IORead) begin
      r_wdata = io_rdata;
    end else if (MemRead) begin
      r_wdata = m_rdata;
    end
  end

  // LED register writes; only the two LED offsets in IO space are writable.
  always_comb begin
    led_d = led_q;
    if (IOWrite && io_hit) begin
      if (io_off == OffLedLo) begin
        led_d[15:0] = r_rdata[15:0];
      end else if (io_off == OffLedHi) begin
        led_d[23:16] = r_rdata[7:0];
      end
    end
  end

  // Switch synchronizer, acceptance into sw_stable and change pulse.
  always_comb begin
    sw_s1_d     = switch;
    sw_s2_d     = sw_s1_q;
    sw_stable_d = sw_stable_q;
`ifdef IO_DEBOUNCE_EN
    cnt_d = '0;
    // A full run of identical candidates is accepted even if sw_s1 is already moving on.
    if (sw_s2_q != sw_stable_q && cnt_q == CntLast) begin
      sw_stable_d = sw_s2_q;
      cnt_d       = '0;
    end else if (sw_s1_q != sw_s2_q) begin
      // Candidate is about to change: restart the run.
      cnt_d = '0;
    end else if (sw_s2_q != sw_stable_q) begin
      cnt_d = cnt_q + DEBOUNCE_W'(1);
    end
`else
    sw_stable_d = sw_s2_q;
`endif
    sw_event_d = (sw_stable_d != sw_stable_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      led_q       <= '0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      sw_stable_q <= '0;
      sw_event_q  <= 1'b0;
`ifdef IO_DEBOUNCE_EN
      cnt_q       <= '0;
`endif
    end else begin
      led_q       <= led_d;
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      sw_stable_q <= sw_stable_d;
      sw_event_q  <= sw_event_d;
`ifdef IO_DEBOUNCE_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule
